// File: rtl/digit_frame_filter_pkg.sv
// Shared definitions for the digit frame-rate stabiliser: bus geometry and sampler FSM states.
package digit_frame_filter_pkg;

  localparam int unsigned DigitW     = 24;
  localparam int unsigned NumNibbles = 6;

  typedef enum logic [1:0] {
    StWaitEdge = 2'd0,
    StDelay    = 2'd1,
    StEval     = 2'd2
  } state_e;

endpackage

// File: rtl/digit_frame_filter_vsync_edge_det.sv
// Leading-edge detector for a frame sync of configurable polarity.
module vsync_edge_det #(
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic lead_edge_o
);

  logic vsync_d, vsync_q;

  assign vsync_d = vsync_i;

  // Previous level resets to the active level so a sync held active across reset release is
  // not mistaken for a fresh frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= VS_ACTIVE;
    end else begin
      vsync_q <= vsync_d;
    end
  end

  assign lead_edge_o = (vsync_i == VS_ACTIVE) && (vsync_q != VS_ACTIVE);

endmodule

// File: rtl/digit_frame_filter.sv
// Frame-rate stabiliser: publishes the recognised digits only after they agree for
// STABLE_FRAMES consecutive frames, with a frame-sync watchdog on the valid flag.
module digit_frame_filter
  import digit_frame_filter_pkg::*;
#(
  parameter int unsigned DIGIT_W       = DigitW,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter logic        VS_ACTIVE     = 1'b0,
  parameter int unsigned SAMPLE_DLY    = 4,
  parameter int unsigned WDOG_CYC      = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_vsync,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  output logic               digit_update,
  output logic [3:0]         stable_cnt
);

  localparam int unsigned     DlyW    = (SAMPLE_DLY > 2) ? $clog2(SAMPLE_DLY) : 1;
  localparam logic [DlyW-1:0] DlyLoad = (SAMPLE_DLY > 1) ? DlyW'(SAMPLE_DLY - 1) : '0;
  localparam int unsigned     WdW     = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WdW-1:0]  WdLast  = WdW'(WDOG_CYC - 1);
  localparam logic [3:0]      SfMax   = 4'(STABLE_FRAMES);

  state_e             state_d, state_q;
  logic [DlyW-1:0]    dly_d, dly_q;
  logic [WdW-1:0]     wdog_d, wdog_q;
  logic [DIGIT_W-1:0] cand_d, cand_q;
  logic [DIGIT_W-1:0] out_d, out_q;
  logic [3:0]         cnt_d, cnt_q;
  logic               valid_d, valid_q;
  logic               pub_d, pub_q;
  logic               upd_d, upd_q;
  logic               lead_edge;

  vsync_edge_det #(
    .VS_ACTIVE (VS_ACTIVE)
  ) u_edge_det (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vsync_i     (frame_vsync),
    .lead_edge_o (lead_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitEdge;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitEdge: if (lead_edge) state_d = StDelay;
      StDelay: begin
        if (lead_edge) begin
          state_d = StDelay;
        end else if (dly_q == '0) begin
          state_d = StEval;
        end
      end
      StEval:  state_d = StWaitEdge;
      default: state_d = StWaitEdge;
    endcase
  end

  always_comb begin
    dly_d = dly_q;
    if (lead_edge) begin
      dly_d = DlyLoad;
    end else if ((state_q == StDelay) && (dly_q != '0)) begin
      dly_d = dly_q - 1'b1;
    end
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    pub_d   = 1'b0;
    upd_d   = pub_q;

    if (state_q == StEval) begin
      if (digit_in == cand_q) begin
        cnt_d = (cnt_q >= SfMax) ? SfMax : cnt_q + 4'd1;
      end else begin
        cand_d = digit_in;
        cnt_d  = 4'd1;
      end
      if ((cnt_d == SfMax) && ((digit_in != out_q) || !valid_q)) begin
        out_d   = digit_in;
        valid_d = 1'b1;
        pub_d   = 1'b1;
      end
    end

    // Watchdog saturates at its last count; a leading edge in the same cycle takes priority.
    if (lead_edge) begin
      wdog_d = '0;
    end else if (wdog_q == WdLast) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
    if (!lead_edge && (wdog_d == WdLast)) begin
      valid_d = 1'b0;
      cnt_d   = 4'd0;
      cand_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q   <= '0;
      wdog_q  <= '0;
      cand_q  <= '0;
      out_q   <= '0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      pub_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      wdog_q  <= wdog_d;
      cand_q  <= cand_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pub_q   <= pub_d;
      upd_q   <= upd_d;
    end
  end

  assign digit_out    = out_q;
  assign digit_valid  = valid_q;
  assign digit_update = upd_q;
  assign stable_cnt   = cnt_q;

endmodule

// File: tb/tb_digit_frame_filter.sv
// Scoreboard bench for digit_frame_filter: frame-level history model drives expected publishes.
module tb_digit_frame_filter;

  localparam int unsigned SF   = 3;
  localparam int unsigned DLY  = 4;
  localparam int unsigned WDOG = 1000;
  localparam time         TCLK = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_vsync = 1'b0;
  logic [23:0] digit_in = '0;
  logic [23:0] digit_out;
  logic        digit_valid;
  logic        digit_update;
  logic [3:0]  stable_cnt;

  always #5 clk = ~clk;

  digit_frame_filter #(
    .DIGIT_W       (24),
    .STABLE_FRAMES (SF),
    .VS_ACTIVE     (1'b0),
    .SAMPLE_DLY    (DLY),
    .WDOG_CYC      (WDOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_vsync  (frame_vsync),
    .digit_in     (digit_in),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .digit_update (digit_update),
    .stable_cnt   (stable_cnt)
  );

  typedef struct {
    logic [23:0] val;
    time         t;
  } pub_t;

  pub_t        exp_q[$];
  pub_t        mon_e;
  logic [23:0] hist[$];
  logic [23:0] m_out = '0;
  logic        m_valid = 1'b0;
  time         last_te = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Length of the trailing run of identical samples since the last clear.
  function automatic int run_len();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic frame(input logic [23:0] val, input int len);
    int r;
    int exp_cnt;
    @(negedge clk);
    digit_in    = val;
    frame_vsync = 1'b0;
    @(posedge clk);
    last_te = $time;
    hist.push_back(val);
    r = run_len();
    if (r >= int'(SF) && ((val != m_out) || !m_valid)) begin
      m_out   = val;
      m_valid = 1'b1;
      exp_q.push_back('{val: val, t: $time + (DLY + 2) * TCLK + TCLK / 2});
    end
    exp_cnt = (r > int'(SF)) ? int'(SF) : r;
    @(negedge clk);
    frame_vsync = 1'b1;
    repeat (len - 2) @(negedge clk);
    check("stable_cnt", 32'(stable_cnt), 32'(exp_cnt));
    check("digit_out", 32'(digit_out), 32'(m_out));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
  endtask

  always @(negedge clk) begin
    if (rst_n && digit_update) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: digit_out=%h at %0t, expected no pulse", digit_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_value", 32'(digit_out), 32'(mon_e.val));
        check("update_time", 32'($time), 32'(mon_e.t));
      end
    end
  end

  initial begin
    logic [23:0] held;
    logic [23:0] v;
    int          k;

    // Vsync held active across reset release must not count as a frame.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_stable_cnt", 32'(stable_cnt), 32'd0);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_out", 32'(digit_out), 32'd0);
    check("rst_update", 32'(digit_update), 32'd0);
    frame_vsync = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) frame(24'h001234, 12);

    // Fresh start for the interrupted-agreement sequence.
    @(negedge clk);
    rst_n = 1'b0;
    hist.delete();
    m_out   = '0;
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frame(24'h001234, 11);
    frame(24'h001234, 11);
    frame(24'h001784, 11);
    frame(24'h001234, 11);
    frame(24'h001234, 11);
    frame(24'h001234, 11);

    frame(24'h005678, 13);
    frame(24'h005678, 13);
    frame(24'h001234, 13);
    frame(24'h001234, 13);

    // Frame sync stops: valid must drop exactly when the watchdog reaches its last count.
    held = digit_out;
    k    = 0;
    while (k < 1100) begin
      @(negedge clk);
      k = int'(($time - last_te - TCLK / 2) / TCLK);
      if (k == int'(WDOG) - 2) check("wdog_valid_before", 32'(digit_valid), 32'd1);
      if (k == int'(WDOG) - 1) begin
        check("wdog_valid_after", 32'(digit_valid), 32'd0);
        check("wdog_out_held", 32'(digit_out), 32'(held));
      end
    end
    hist.delete();
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) frame(24'h001234, 12);

    // Reset lands in DELAY of the third qualifying frame of a new value.
    frame(24'h009876, 12);
    frame(24'h009876, 12);
    @(negedge clk);
    digit_in    = 24'h009876;
    frame_vsync = 1'b0;
    @(negedge clk);
    frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(digit_out), 32'd0);
    check("mid_rst_valid", 32'(digit_valid), 32'd0);
    check("mid_rst_cnt", 32'(stable_cnt), 32'd0);
    hist.delete();
    m_out   = '0;
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) frame(24'h009876, 12);

    // Randomised frames biased towards runs of repeated values.
    v = 24'h001234;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 3))
          0: v = 24'h001234;
          1: v = 24'h001784;
          2: v = 24'h005678;
          default: for (int n = 0; n < 6; n++) v[n*4 +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      frame(v, int'($urandom_range(10, 16)));
    end

    repeat (20) @(negedge clk);
    check("pending_updates", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
